rv32_fetch_stage: RTL and testbench

//  Instruction fetch stage of the rv32 five-stage pipeline: owns the PC and drives the instruction bus.

---
 rtl/rv32_fetch_pkg.sv | 5 +
 rtl/rv32_fetch_stage.sv | 106 ++++++++++
 tb/tb_rv32_fetch_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: shared fetch-stage state encoding and instruction constants.
package rv32_fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetch_state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/rv32_fetch_stage.sv
// rv32_fetch_stage: owns the PC, drives the instruction bus and fills the decode pipeline register.
module rv32_fetch_stage
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] instr_address_out,
    output logic        instr_read_out,
    input  logic [31:0] instr_value_in,
    input  logic        instr_ready_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, redirect_q, redirect_d, buf_q, buf_d;
    logic [31:0]  pc_out_q, pc_out_d, instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         reading, hold_pipe;
    logic [31:0]  target;

    assign reading   = state_q == FETCH || state_q == DISCARD;
    assign hold_pipe = stall_in || flush_in;
    assign target    = branch_pc_in & ~32'd3;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = redirect_q;
        buf_d      = buf_q;
        valid_d    = valid_q;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        if (state_q == IDLE) begin
            state_d = FETCH;
        end else if (branch_taken_in) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            // an outstanding read must finish at its old address before the target is issued
            if (reading && !instr_ready_in) begin
                redirect_d = target;
                state_d    = DISCARD;
            end else begin
                pc_d    = target;
                state_d = FETCH;
            end
        end else begin
            if (flush_in || !stall_in) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            if (state_q == FETCH && instr_ready_in) begin
                if (hold_pipe) begin
                    buf_d   = instr_value_in;
                    state_d = HOLD;
                end else begin
                    valid_d  = 1'b1;
                    pc_out_d = pc_q;
                    instr_d  = instr_value_in;
                    pc_d     = pc_q + 32'd4;
                end
            end else if (state_q == HOLD && !hold_pipe) begin
                valid_d  = 1'b1;
                pc_out_d = pc_q;
                instr_d  = buf_q;
                pc_d     = pc_q + 32'd4;
                state_d  = FETCH;
            end else if (state_q == DISCARD && instr_ready_in) begin
                pc_d    = redirect_q;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            redirect_q <= '0;
            buf_q      <= '0;
            valid_q    <= 1'b0;
            pc_out_q   <= '0;
            instr_q    <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            buf_q      <= buf_d;
            valid_q    <= valid_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
        end
    end

    assign instr_address_out = pc_q & ~32'd3;
    assign instr_read_out    = reading;
    assign valid_out         = valid_q;
    assign pc_out            = pc_out_q;
    assign instr_out         = instr_q;
endmodule

// File: tb/tb_rv32_fetch_stage.sv
// tb_rv32_fetch_stage: directed and random fetch scenarios checked by a program-order scoreboard.
module tb_rv32_fetch_stage;
    import rv32_fetch_pkg::*;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        stall_in = 1'b0, flush_in = 1'b0, branch_taken_in = 1'b0, instr_ready_in = 1'b0;
    logic [31:0] branch_pc_in = '0, instr_value_in = '0;
    logic [31:0] instr_address_out, pc_out, instr_out;
    logic        instr_read_out, valid_out;

    int          errors = 0, checks = 0, deliveries = 0;
    logic        bus_hold = 1'b0, rand_mode = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] prev_pc, prev_instr, saved_pc, saved_instr, m_addr, e;
    logic        prev_valid, m_live, m_load, m_freeze, m_kill, m_pend;

    rv32_fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
        .branch_taken_in(branch_taken_in), .branch_pc_in(branch_pc_in),
        .instr_address_out(instr_address_out), .instr_read_out(instr_read_out),
        .instr_value_in(instr_value_in), .instr_ready_in(instr_ready_in),
        .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // bus slave answers the current request, then time advances to the next falling edge
    task automatic cyc();
        instr_ready_in = instr_read_out && !bus_hold && (!rand_mode || $urandom_range(2) != 0);
        instr_value_in = instr_ready_in ? mem_word(instr_address_out) : $urandom;
        @(negedge clk);
    endtask

    task automatic do_branch(input logic [31:0] t);
        exp_q.delete();
        exp_q.push_back(t & ~32'd3);
        branch_taken_in = 1'b1;
        branch_pc_in    = t;
        cyc();
        branch_taken_in = 1'b0;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n = 0;
        while (instr_address_out !== a && n < 50) begin
            cyc();
            n++;
        end
        check("wait_addr", instr_address_out, a);
    endtask

    always @(posedge clk) begin
        m_live   = reset_n;
        m_load   = !stall_in && !flush_in && !branch_taken_in;
        m_freeze = stall_in && !flush_in && !branch_taken_in;
        m_kill   = flush_in || branch_taken_in;
        m_pend   = instr_read_out && !instr_ready_in;
        m_addr   = instr_address_out;
        #1;
        if (m_live && reset_n) begin
            if (m_pend) begin
                check("bus_read_held", {31'd0, instr_read_out}, 32'd1);
                check("bus_addr_held", instr_address_out, m_addr);
            end
            if (m_kill) begin
                check("kill_bubble", {31'd0, valid_out}, 32'd0);
            end else if (m_freeze) begin
                check("stall_valid", {31'd0, valid_out}, {31'd0, prev_valid});
                check("stall_pc", pc_out, prev_pc);
                check("stall_instr", instr_out, prev_instr);
            end else if (m_load && valid_out) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", pc_out, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
                    check("sb_pc", pc_out, e);
                    check("sb_instr", instr_out, mem_word(e));
                    deliveries++;
                end
            end
            if (!valid_out) check("bubble_nop", instr_out, NOP_INSTR);
            check("addr_align", instr_address_out & 32'd3, 32'd0);
        end
        prev_valid = valid_out;
        prev_pc    = pc_out;
        prev_instr = instr_out;
    end

    initial begin
        exp_q.push_back(32'h0);
        cyc();
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instr_out, NOP_INSTR);
        check("rst_read", {31'd0, instr_read_out}, 32'd0);
        reset_n = 1'b1;
        cyc();
        check("t1_addr0", instr_address_out, 32'h0);
        check("t1_no_valid_yet", {31'd0, valid_out}, 32'd0);
        cyc();
        check("t1_first_valid", {31'd0, valid_out}, 32'd1);
        check("t1_pc0", pc_out, 32'h0);
        check("t1_addr4", instr_address_out, 32'h4);
        cyc();
        check("t1_addr8", instr_address_out, 32'h8);

        wait_addr(32'h10);
        bus_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t2_addr_held", instr_address_out, 32'h10);
            check("t2_wait_bubble", {31'd0, valid_out}, 32'd0);
        end
        bus_hold = 1'b0;
        cyc();
        check("t2_pc10", pc_out, 32'h10);
        check("t2_next_addr", instr_address_out, 32'h14);
        cyc();
        check("t2_pc10_once", pc_out, 32'h14);

        wait_addr(32'h20);
        stall_in = 1'b1;
        cyc();
        check("t3_hold_read", {31'd0, instr_read_out}, 32'd0);
        saved_pc    = pc_out;
        saved_instr = instr_out;
        check("t3_held_pc", saved_pc, 32'h1C);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("t3_frozen_pc", pc_out, saved_pc);
            check("t3_frozen_instr", instr_out, saved_instr);
            check("t3_read_off", {31'd0, instr_read_out}, 32'd0);
        end
        stall_in = 1'b0;
        cyc();
        check("t3_valid", {31'd0, valid_out}, 32'd1);
        check("t3_pc20", pc_out, 32'h20);
        check("t3_addr24", instr_address_out, 32'h24);

        wait_addr(32'h30);
        bus_hold = 1'b1;
        cyc();
        do_branch(32'h100);
        check("t4_addr_kept", instr_address_out, 32'h30);
        check("t4_read_kept", {31'd0, instr_read_out}, 32'd1);
        cyc();
        check("t4_addr_kept2", instr_address_out, 32'h30);
        bus_hold = 1'b0;
        cyc();
        check("t4_dropped", {31'd0, valid_out}, 32'd0);
        check("t4_addr100", instr_address_out, 32'h100);
        cyc();
        check("t4_pc100", pc_out, 32'h100);

        wait_addr(32'h110);
        bus_hold = 1'b1;
        cyc();
        do_branch(32'h200);
        check("t5_addr_kept", instr_address_out, 32'h110);
        do_branch(32'h300);
        check("t5_addr_kept2", instr_address_out, 32'h110);
        bus_hold = 1'b0;
        cyc();
        check("t5_addr300", instr_address_out, 32'h300);
        cyc();
        check("t5_pc300", pc_out, 32'h300);

        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall_in = $urandom_range(3) == 0;
            flush_in = $urandom_range(7) == 0;
            if ($urandom_range(15) == 0) do_branch($urandom);
            else cyc();
        end
        rand_mode = 1'b0;
        stall_in  = 1'b0;
        flush_in  = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("rand_deliveries", {31'd0, deliveries > 500}, 32'd1);

        do_branch(32'hFFFF_FFFF);
        check("t6_addr_top", instr_address_out, 32'hFFFF_FFFC);
        cyc();
        check("t6_pc_top", pc_out, 32'hFFFF_FFFC);
        check("t6_wrap", instr_address_out, 32'h0);
        bus_hold = 1'b1;
        cyc();
        check("t6_pending", {31'd0, instr_read_out}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_async_read", {31'd0, instr_read_out}, 32'd0);
        check("t6_async_valid", {31'd0, valid_out}, 32'd0);
        check("t6_async_instr", instr_out, NOP_INSTR);
        exp_q.delete();
        exp_q.push_back(32'h0);
        bus_hold = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        check("t6_restart_valid", {31'd0, valid_out}, 32'd1);
        check("t6_restart_pc", pc_out, 32'h0);
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
